// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register file write port between two buffered requesters
module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Freeze,
    input  logic              Req0_Valid,
    input  logic [ADDR_W-1:0] Req0_RD,
    input  logic [DATA_W-1:0] Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [ADDR_W-1:0] Req1_RD,
    input  logic [DATA_W-1:0] Req1_Data,
    output logic              Req1_Ready,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Last_Grant
);
    logic [1:0]        full;
    logic [1:0]        sel;
    logic [1:0]        accept;
    logic [ADDR_W-1:0] buf_rd   [2];
    logic [DATA_W-1:0] buf_data [2];
    logic [ADDR_W-1:0] in_rd    [2];
    logic [DATA_W-1:0] in_data  [2];

    // On a tie the requester that did not win last time is granted
    always_comb begin
        sel[0] = ~Freeze & full[0] & (~full[1] | Last_Grant);
        sel[1] = ~Freeze & full[1] & (~full[0] | ~Last_Grant);
    end

    assign Req0_Ready = ~full[0] | sel[0];
    assign Req1_Ready = ~full[1] | sel[1];
    assign accept     = {Req1_Valid & Req1_Ready, Req0_Valid & Req0_Ready};
    assign in_rd[0]   = Req0_RD;
    assign in_rd[1]   = Req1_RD;
    assign in_data[0] = Req0_Data;
    assign in_data[1] = Req1_Data;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            full <= '0;
            for (int k = 0; k < 2; k++) begin
                buf_rd[k]   <= '0;
                buf_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (accept[k]) begin
                    full[k]     <= 1'b1;
                    buf_rd[k]   <= in_rd[k];
                    buf_data[k] <= in_data[k];
                end else if (sel[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end

    // Address and data hold their last issued values while idle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Reg_Write  <= 1'b0;
            RD         <= '0;
            Write_Data <= '0;
            Last_Grant <= 1'b1;
        end else begin
            Reg_Write <= |sel;
            if (|sel) begin
                RD         <= sel[1] ? buf_rd[1] : buf_rd[0];
                Write_Data <= sel[1] ? buf_data[1] : buf_data[0];
                Last_Grant <= sel[1];
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: table-driven vectors with per-requester scoreboards for regfile_write_arbiter
module tb_regfile_write_arbiter;
    typedef struct {
        logic       frz, v0, v1, r0, r1, wr, lg;
        logic [2:0] rd0, rd1;
        logic [7:0] d0, d1;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Freeze = 1'b0;
    logic       Req0_Valid = 1'b0, Req1_Valid = 1'b0;
    logic [2:0] Req0_RD = '0, Req1_RD = '0;
    logic [7:0] Req0_Data = '0, Req1_Data = '0;
    logic       Req0_Ready, Req1_Ready, Reg_Write, Last_Grant;
    logic [2:0] RD;
    logic [7:0] Write_Data;

    int          pass_cnt = 0;
    int          total = 0;
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [7:0]  regs [8];
    logic [7:0]  exp_regs [8] = '{8'h84, 8'h41, 8'h22, 8'h43, 8'h55, 8'h5A, 8'h66, 8'h83};
    vec_t        vecs[$];

    always #5 Clk = ~Clk;

    regfile_write_arbiter dut (
        .Clk(Clk), .Reset(Reset), .Freeze(Freeze),
        .Req0_Valid(Req0_Valid), .Req0_RD(Req0_RD), .Req0_Data(Req0_Data), .Req0_Ready(Req0_Ready),
        .Req1_Valid(Req1_Valid), .Req1_RD(Req1_RD), .Req1_Data(Req1_Data), .Req1_Ready(Req1_Ready),
        .Reg_Write(Reg_Write), .RD(RD), .Write_Data(Write_Data), .Last_Grant(Last_Grant)
    );

    task automatic chk(string n, int act, int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    function automatic vec_t mk(input int frz, v0, rd0, d0, v1, rd1, d1, r0, r1, wr, lg);
        vec_t r;
        r.frz = 1'(frz); r.v0 = 1'(v0); r.rd0 = 3'(rd0); r.d0 = 8'(d0);
        r.v1 = 1'(v1); r.rd1 = 3'(rd1); r.d1 = 8'(d1);
        r.r0 = 1'(r0); r.r1 = 1'(r1); r.wr = 1'(wr); r.lg = 1'(lg);
        return r;
    endfunction

    task automatic idle_inputs();
        Freeze = 1'b0; Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    endtask

    task automatic rst_chk(string tag);
        chk({tag, " rst Reg_Write"}, int'(Reg_Write), 0);
        chk({tag, " rst RD"}, int'(RD), 0);
        chk({tag, " rst Write_Data"}, int'(Write_Data), 0);
        chk({tag, " rst Last_Grant"}, int'(Last_Grant), 1);
    endtask

    // Drives one cycle at a negedge, checks Ready, then checks the write produced by the next edge
    task automatic step(string tag, vec_t v);
        logic [10:0] e;
        Freeze = v.frz;
        Req0_Valid = v.v0; Req0_RD = v.rd0; Req0_Data = v.d0;
        Req1_Valid = v.v1; Req1_RD = v.rd1; Req1_Data = v.d1;
        #1;
        chk({tag, " Req0_Ready"}, int'(Req0_Ready), int'(v.r0));
        chk({tag, " Req1_Ready"}, int'(Req1_Ready), int'(v.r1));
        if (v.v0 && v.r0) q0.push_back({v.rd0, v.d0});
        if (v.v1 && v.r1) q1.push_back({v.rd1, v.d1});
        @(posedge Clk);
        @(negedge Clk);
        chk({tag, " Reg_Write"}, int'(Reg_Write), int'(v.wr));
        if (Reg_Write) begin
            if (v.wr) chk({tag, " Last_Grant"}, int'(Last_Grant), int'(v.lg));
            if (Last_Grant ? q1.size() == 0 : q0.size() == 0) begin
                total++;
                $display("FAIL %s write: got RD=%0h data=%0h expected no write (requester %0d empty)", tag, RD, Write_Data, Last_Grant);
            end else begin
                e = Last_Grant ? q1.pop_front() : q0.pop_front();
                chk({tag, " RD/Write_Data"}, int'({RD, Write_Data}), int'(e));
            end
            regs[RD] = Write_Data;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = '0;
        // single Req0 write
        vecs.push_back(mk(0, 1, 3, 'hA5, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        // Req1 streams alone
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 0, 0, 1, i, 'h10 + i, 1, 1, int'(i > 0), 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        // both requesters continuously valid; items held until accepted
        vecs.push_back(mk(0, 1, 1, 'h41, 1, 5, 'h81, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2, 'h42, 1, 6, 'h82, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3, 'h43, 1, 6, 'h82, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 3, 'h43, 1, 7, 'h83, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 4, 'h44, 1, 7, 'h83, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 4, 'h44, 1, 0, 'h84, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h84, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        // same destination from both
        vecs.push_back(mk(0, 1, 2, 'h11, 1, 2, 'h22, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        // freeze with both buffers full, competing data offered meanwhile
        vecs.push_back(mk(0, 1, 4, 'h55, 1, 6, 'h66, 1, 1, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 7, 'hEE, 1, 7, 'hFF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        // an empty buffer still accepts one entry while frozen
        vecs.push_back(mk(1, 1, 5, 'h5A, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));

        #1 Reset = 1'b0;
        @(negedge Clk);
        #1 rst_chk("init");
        @(posedge Clk);
        @(negedge Clk);
        rst_chk("init hold");
        Reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step($sformatf("v%0d", i), vecs[i]);
        for (int i = 0; i < 8; i++) chk($sformatf("regfile[%0d]", i), int'(regs[i]), int'(exp_regs[i]));

        // asynchronous reset between edges with both buffers full and a write on the port
        step("t6a", mk(0, 1, 1, 'h77, 1, 5, 'h99, 1, 1, 0, 0));
        step("t6b", mk(0, 0, 0, 0, 1, 5, 'h9B, 0, 1, 1, 1));
        idle_inputs();
        #2 Reset = 1'b0;
        #1 rst_chk("async");
        q0.delete();
        q1.delete();
        @(posedge Clk);
        @(negedge Clk);
        rst_chk("async hold");
        Reset = 1'b1;
        step("t6c", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        step("t6d", mk(0, 1, 6, 'hC6, 1, 7, 'hD7, 1, 1, 0, 0));
        step("t6e", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        step("t6f", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        step("t6g", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
